// File: rtl/pipelined_select_adder_pkg.sv
// Shared constants and the per-stage beat record for the pipelined carry-select adder.
// The record carries the control bits that travel with a beat from stage to stage.
package pipelined_select_adder_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_BLOCK = 8;

    // Control part of a beat; the sum/operand slices travel in WIDTH-wide vectors alongside.
    typedef struct packed {
        logic valid;
        logic carry;
        logic sub;
        logic ovf;
    } stageCtl_t;

    // Subtraction forces the carry-in to 1 so that A + ~B + 1 = A - B.
    function automatic logic effCarry(input logic isSub, input logic carryIn);
        return isSub | carryIn;
    endfunction

endpackage

// File: rtl/pipelined_select_adder_csel_block.sv
// Combinational BLOCK-bit carry-select slice: both carry hypotheses are summed in
// parallel and the incoming carry picks one. cmsb is the carry into the slice MSB.
module csel_block #(
    parameter int BLOCK = 8
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] s,
    output logic             cout,
    output logic             cmsb
);

    logic [BLOCK:0] sum0;
    logic [BLOCK:0] sum1;

    always_comb begin
        sum0 = {1'b0, a} + {1'b0, b};
        sum1 = {1'b0, a} + {1'b0, b} + {{BLOCK{1'b0}}, 1'b1};
        {cout, s} = cin ? sum1 : sum0;
        // Carry into the MSB recovered from the sum bit: s = a ^ b ^ c.
        cmsb = s[BLOCK-1] ^ a[BLOCK-1] ^ b[BLOCK-1];
    end

endmodule

// File: rtl/pipelined_select_adder.sv
// Pipelined carry-select adder/subtractor: one BLOCK-bit slice resolved per stage,
// NBLK stages deep, with a global stall when the output beat is not taken.
module pipelined_select_adder
    import pipelined_select_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int BLOCK = DEFAULT_BLOCK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf,
    output logic [15:0]      op_count
);

    localparam int NBLK = WIDTH / BLOCK;

    if (BLOCK < 1 || (WIDTH % BLOCK) != 0) begin : g_bad_width
        $error("pipelined_select_adder: WIDTH must be a positive multiple of BLOCK");
    end

    stageCtl_t        ctlQ [NBLK];
    // Bits below the current block hold finished sum slices; bits above still hold raw A.
    logic [WIDTH-1:0] accQ [NBLK];
    logic [WIDTH-1:0] bQ   [NBLK];
    logic             stall;
    logic [15:0]      opCountQ;

    assign stall    = ctlQ[NBLK-1].valid && !out_ready;
    assign in_ready = !stall;

    for (genvar k = 0; k < NBLK; k++) begin : g_stage
        localparam int LO = k * BLOCK;

        stageCtl_t        ctlIn;
        logic [WIDTH-1:0] accIn;
        logic [WIDTH-1:0] bIn;
        logic [WIDTH-1:0] accNext;
        logic [BLOCK-1:0] bSlice;
        logic [BLOCK-1:0] sumSlice;
        logic             carryOut;
        logic             carryMsb;

        if (k == 0) begin : g_src
            always_comb begin
                ctlIn.valid = in_valid;
                ctlIn.carry = effCarry(sub, cin);
                ctlIn.sub   = sub;
                ctlIn.ovf   = 1'b0;
                accIn       = A;
                bIn         = B;
            end
        end else begin : g_src
            always_comb begin
                ctlIn = ctlQ[k-1];
                accIn = accQ[k-1];
                bIn   = bQ[k-1];
            end
        end

        // B travels unmodified; each stage inverts only the slice it consumes.
        assign bSlice = bIn[LO +: BLOCK] ^ {BLOCK{ctlIn.sub}};

        csel_block #(
            .BLOCK(BLOCK)
        ) u_csel (
            .a    (accIn[LO +: BLOCK]),
            .b    (bSlice),
            .cin  (ctlIn.carry),
            .s    (sumSlice),
            .cout (carryOut),
            .cmsb (carryMsb)
        );

        always_comb begin
            // NOTE: start from a full default so every bit is assigned on every path; no latch.
            accNext              = accIn;
            accNext[LO +: BLOCK] = sumSlice;
        end

        // NOTE: non-blocking assignments so every stage samples its predecessor's old value.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                ctlQ[k] <= '0;
                accQ[k] <= '0;
                bQ[k]   <= '0;
            end else if (!stall) begin
                ctlQ[k] <= '{valid: ctlIn.valid, carry: carryOut, sub: ctlIn.sub,
                             ovf: carryOut ^ carryMsb};
                accQ[k] <= accNext;
                bQ[k]   <= bIn;
            end
        end
    end

    assign out_valid = ctlQ[NBLK-1].valid;
    assign S         = accQ[NBLK-1];
    assign Cout      = ctlQ[NBLK-1].carry;
    assign Ovf       = ctlQ[NBLK-1].ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opCountQ <= '0;
        end else if (out_valid && out_ready && opCountQ != 16'hFFFF) begin
            opCountQ <= opCountQ + 16'd1;
        end
    end

    assign op_count = opCountQ;

endmodule

// File: tb/tb_pipelined_select_adder.sv
// Self-checking bench for pipelined_select_adder: directed vectors, stall and reset
// sequences on a 32/8 instance, random streams on 32/8, 16/16 and 64/4 instances.
module tb_pipelined_select_adder;

    localparam int W0 = 32, B0 = 8,  N0 = W0 / B0;
    localparam int W1 = 16, B1 = 16;
    localparam int W2 = 64, B2 = 4;

    typedef struct {
        logic [63:0] s;
        logic        cout;
        logic        ovf;
        int          inCycle;
        bit          chkLat;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        cin;
        logic [31:0] s;
        logic        cout;
        logic        ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cycle = 0;
    int   nCompared = 0;
    int   nMismatched = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    logic          in_valid0 = 0, in_ready0, sub0 = 0, cin0 = 0, out_valid0, out_ready0 = 1, cout0, ovf0;
    logic [W0-1:0] a0 = '0, b0 = '0, s0;
    logic [15:0]   opc0;
    logic          in_valid1 = 0, in_ready1, sub1 = 0, cin1 = 0, out_valid1, out_ready1 = 1, cout1, ovf1;
    logic [W1-1:0] a1 = '0, b1 = '0, s1;
    logic [15:0]   opc1;
    logic          in_valid2 = 0, in_ready2, sub2 = 0, cin2 = 0, out_valid2, out_ready2 = 1, cout2, ovf2;
    logic [W2-1:0] a2 = '0, b2 = '0, s2;
    logic [15:0]   opc2;

    pipelined_select_adder #(.WIDTH(W0), .BLOCK(B0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .A(a0), .B(b0),
        .sub(sub0), .cin(cin0), .out_valid(out_valid0), .out_ready(out_ready0), .S(s0),
        .Cout(cout0), .Ovf(ovf0), .op_count(opc0));
    pipelined_select_adder #(.WIDTH(W1), .BLOCK(B1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .A(a1), .B(b1),
        .sub(sub1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1), .S(s1),
        .Cout(cout1), .Ovf(ovf1), .op_count(opc1));
    pipelined_select_adder #(.WIDTH(W2), .BLOCK(B2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .A(a2), .B(b2),
        .sub(sub2), .cin(cin2), .out_valid(out_valid2), .out_ready(out_ready2), .S(s2),
        .Cout(cout2), .Ovf(ovf2), .op_count(opc2));

    exp_t q0[$], q1[$], q2[$];
    exp_t curExp0, curExp1, curExp2;
    int   outCnt0 = 0, outCnt1 = 0, outCnt2 = 0;
    int   firstOut0 = 0, lastOut0 = 0;
    vec_t tbl [12];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural (w+1)-bit reference; returns {Cout, Ovf, S}.
    function automatic logic [65:0] refModel(input int w, input logic [63:0] a, input logic [63:0] b,
                                             input logic isSub, input logic carryIn);
        logic [64:0] full;
        logic [63:0] mask, aM, bEff;
        logic        c;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        aM   = a & mask;
        bEff = (isSub ? ~b : b) & mask;
        c    = isSub ? 1'b1 : carryIn;
        full = {1'b0, aM} + {1'b0, bEff} + {64'd0, c};
        return {full[w], (aM[w-1] == bEff[w-1]) && (full[w-1] != aM[w-1]), full[63:0] & mask};
    endfunction

    always @(negedge clk) begin : mon0
        exp_t e;
        if (rst) begin
            q0.delete();
            outCnt0 = 0;
        end else begin
            if (out_valid0 && out_ready0) begin
                if (q0.size() == 0) check("dut32 unexpected result", {cout0, ovf0, s0}, 128'hDEAD);
                else begin
                    e = q0.pop_front();
                    check("dut32 {Cout,Ovf,S}", {cout0, ovf0, s0}, {e.cout, e.ovf, e.s[31:0]});
                    if (e.chkLat) check("dut32 latency", cycle - e.inCycle, N0);
                    if (outCnt0 == 0) firstOut0 = cycle;
                    lastOut0 = cycle;
                    outCnt0++;
                end
            end
            if (in_valid0 && in_ready0) begin
                e = curExp0;
                e.inCycle = cycle;
                q0.push_back(e);
            end
        end
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (rst) begin
            q1.delete();
            outCnt1 = 0;
        end else begin
            if (out_valid1 && out_ready1) begin
                if (q1.size() == 0) check("dut16 unexpected result", {cout1, ovf1, s1}, 128'hDEAD);
                else begin
                    e = q1.pop_front();
                    check("dut16 {Cout,Ovf,S}", {cout1, ovf1, s1}, {e.cout, e.ovf, e.s[15:0]});
                    outCnt1++;
                end
            end
            if (in_valid1 && in_ready1) q1.push_back(curExp1);
        end
    end

    always @(negedge clk) begin : mon2
        exp_t e;
        if (rst) begin
            q2.delete();
            outCnt2 = 0;
        end else begin
            if (out_valid2 && out_ready2) begin
                if (q2.size() == 0) check("dut64 unexpected result", {cout2, ovf2, s2}, 128'hDEAD);
                else begin
                    e = q2.pop_front();
                    check("dut64 {Cout,Ovf,S}", {cout2, ovf2, s2}, {e.cout, e.ovf, e.s});
                    outCnt2++;
                end
            end
            if (in_valid2 && in_ready2) q2.push_back(curExp2);
        end
    end

    // Called at posedge+1 with in_valid high; returns at posedge+1 after the accepting edge.
    task automatic waitAccept(input int which, input string name);
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if ((which == 0 && in_ready0) || (which == 1 && in_ready1) || (which == 2 && in_ready2)) begin
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        check({name, " accept timeout"}, 1, 0);
    endtask

    task automatic send0(input logic [31:0] a, input logic [31:0] b, input logic isSub, input logic carryIn,
                         input logic [31:0] es, input logic ec, input logic eo, input bit lat);
        a0 = a; b0 = b; sub0 = isSub; cin0 = carryIn;
        curExp0 = '{s: {32'd0, es}, cout: ec, ovf: eo, inCycle: 0, chkLat: lat};
        in_valid0 = 1'b1;
        waitAccept(0, "dut32");
        in_valid0 = 1'b0;
    endtask

    task automatic send0Rand();
        logic [31:0] a, b;
        logic        isSub, carryIn;
        logic [65:0] r;
        a = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
        b = ($urandom_range(0, 3) == 0) ? 32'h00000001 : $urandom;
        isSub = 1'($urandom_range(0, 1));
        carryIn = 1'($urandom_range(0, 1));
        r = refModel(W0, {32'd0, a}, {32'd0, b}, isSub, carryIn);
        send0(a, b, isSub, carryIn, r[31:0], r[65], r[64], 1'b0);
    endtask

    task automatic send1Rand();
        logic [65:0] r;
        a1 = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
        b1 = 16'($urandom);
        sub1 = 1'($urandom_range(0, 1));
        cin1 = 1'($urandom_range(0, 1));
        r = refModel(W1, {48'd0, a1}, {48'd0, b1}, sub1, cin1);
        curExp1 = '{s: r[63:0], cout: r[65], ovf: r[64], inCycle: 0, chkLat: 1'b0};
        in_valid1 = 1'b1;
        waitAccept(1, "dut16");
        in_valid1 = 1'b0;
    endtask

    task automatic send2Rand();
        logic [65:0] r;
        a2 = ($urandom_range(0, 3) == 0) ? 64'hFFFFFFFF_FFFFFFFF : {$urandom, $urandom};
        b2 = {$urandom, $urandom};
        sub2 = 1'($urandom_range(0, 1));
        cin2 = 1'($urandom_range(0, 1));
        r = refModel(W2, a2, b2, sub2, cin2);
        curExp2 = '{s: r[63:0], cout: r[65], ovf: r[64], inCycle: 0, chkLat: 1'b0};
        in_valid2 = 1'b1;
        waitAccept(2, "dut64");
        in_valid2 = 1'b0;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while ((q0.size() != 0 || q1.size() != 0 || q2.size() != 0) && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        check({name, " queues drained"}, q0.size() + q1.size() + q2.size(), 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [33:0] held;
        bit          rndDone;
        bit          stale;

        tbl[0]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
        tbl[1]  = '{32'h00000000, 32'h00000001, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0};
        tbl[2]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
        tbl[3]  = '{32'h12345678, 32'h98765432, 1'b0, 1'b0, 32'hAAAAAAAA, 1'b0, 1'b0};
        tbl[4]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0};
        tbl[5]  = '{32'h12378945, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h12378944, 1'b1, 1'b0};
        tbl[6]  = '{32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1};
        tbl[7]  = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000001, 1'b0, 1'b0};
        tbl[8]  = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0};
        tbl[9]  = '{32'h00FFFFFF, 32'h00000000, 1'b0, 1'b1, 32'h01000000, 1'b0, 1'b0};
        tbl[10] = '{32'h00000005, 32'h00000005, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};
        tbl[11] = '{32'h00000003, 32'h00000005, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};

        // Reset state, including an offered beat while reset is held.
        #1 rst = 1'b1;
        #2;
        check("reset out_valid", out_valid0, 0);
        check("reset in_ready", in_ready0, 1);
        check("reset op_count", opc0, 0);
        check("reset {Cout,Ovf,S}", {cout0, ovf0, s0}, 0);
        in_valid0 = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("in reset out_valid", out_valid0, 0);
        check("in reset in_ready", in_ready0, 1);
        in_valid0 = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        // Directed vectors streamed back to back.
        for (int i = 0; i < 12; i++)
            send0(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].cin, tbl[i].s, tbl[i].cout, tbl[i].ovf, 1'b1);
        drain("table");
        #1;
        check("table results delivered", outCnt0, 12);
        check("table results consecutive", lastOut0 - firstOut0, 11);
        check("table op_count", opc0, 12);

        // Six-cycle output stall in the middle of a stream.
        fork
            begin
                for (int i = 0; i < 8; i++) send0Rand();
            end
            begin
                repeat (6) @(posedge clk);
                #1 out_ready0 = 1'b0;
                #1;
                check("stall out_valid", out_valid0, 1);
                check("stall in_ready", in_ready0, 0);
                held = {cout0, ovf0, s0};
                for (int i = 0; i < 5; i++) begin
                    @(posedge clk);
                    #2;
                    check("stall in_ready", in_ready0, 0);
                    check("stall output held", {cout0, ovf0, s0}, held);
                end
                @(posedge clk);
                #1 out_ready0 = 1'b1;
            end
        join
        drain("stall");
        #1;
        check("stall results delivered", outCnt0, 20);
        check("stall op_count", opc0, outCnt0);

        // Random traffic with random backpressure on all three geometries.
        rndDone = 1'b0;
        fork
            begin
                fork
                    for (int i = 0; i < 150; i++) begin
                        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                        send0Rand();
                    end
                    for (int i = 0; i < 150; i++) begin
                        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                        send1Rand();
                    end
                    for (int i = 0; i < 150; i++) begin
                        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                        send2Rand();
                    end
                join
                rndDone = 1'b1;
            end
            while (!rndDone) begin
                @(posedge clk);
                #1;
                out_ready0 = ($urandom_range(0, 3) != 0);
                out_ready1 = ($urandom_range(0, 3) != 0);
                out_ready2 = ($urandom_range(0, 3) != 0);
            end
        join
        out_ready0 = 1'b1;
        out_ready1 = 1'b1;
        out_ready2 = 1'b1;
        drain("random");
        #1;
        check("random dut32 op_count", opc0, outCnt0);
        check("random dut16 op_count", opc1, outCnt1);
        check("random dut64 op_count", opc2, outCnt2);
        check("random dut16 count", outCnt1, 150);
        check("random dut64 count", outCnt2, 150);

        // Reset with three beats in flight: nothing may emerge afterwards.
        for (int i = 0; i < 3; i++) send0Rand();
        rst = 1'b1;
        #1;
        check("mid reset out_valid", out_valid0, 0);
        check("mid reset op_count", opc0, 0);
        check("mid reset in_ready", in_ready0, 1);
        check("mid reset {Cout,Ovf,S}", {cout0, ovf0, s0}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        stale = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #2;
            if (out_valid0) stale = 1'b1;
        end
        check("no stale result after reset", stale, 0);
        send0(tbl[5].a, tbl[5].b, tbl[5].sub, tbl[5].cin, tbl[5].s, tbl[5].cout, tbl[5].ovf, 1'b1);
        drain("post reset");
        #1;
        check("post reset op_count", opc0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
